// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state and strobe encodings for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10,
    ERR    = 2'b11
  } state_t;

  // Memory strobes are active-low.
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_RD, mem_WR;
  logic [ADDR_W-1:0] mem_DAddr;
  logic [DATA_W-1:0] mem_DataIn;
  logic [DATA_W-1:0] mem_DataOut;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output mem_RD, mem_WR, mem_DAddr, mem_DataIn,
    input  mem_DataOut
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err0, err1, rdata0, rdata1,
    input  mem_RD, mem_WR, mem_DAddr, mem_DataIn,
    output mem_DataOut
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic gnt_valid_o,
  output logic gnt_id_o
);

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_id_o    = 1'b0;
    // On contention the port that did not win last time goes first.
    if (req0_i && req1_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (req1_i) begin
      gnt_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin sequencer for the big-endian data memory
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic          CLK,
  input  logic          Reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              gnt_valid, gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  rr_arb2 u_rr_arb2 (
    .req0_i      (bus.req0),
    .req1_i      (bus.req1),
    .last_grant_i(last_grant_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  assign sel_we    = gnt_id ? bus.we1    : bus.we0;
  assign sel_addr  = gnt_id ? bus.addr1  : bus.addr0;
  assign sel_wdata = gnt_id ? bus.wdata1 : bus.wdata0;
  assign sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= LAST_WORD);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    rd_d         = STROBE_OFF;
    wr_d         = STROBE_OFF;
    daddr_d      = daddr_q;
    din_d        = din_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_d        = gnt_id;
          last_grant_d = gnt_id;
          we_d         = sel_we;
          daddr_d      = sel_addr;
          din_d        = sel_wdata;
          if (sel_legal) begin
            state_d = ACCESS;
            if (sel_we) wr_d = STROBE_ON;
            else        rd_d = STROBE_ON;
          end else begin
            // Rejected accesses never touch the memory strobes.
            state_d = ERR;
            err0_d  = ~gnt_id;
            err1_d  = gnt_id;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (gnt_q) rdata1_d = bus.mem_DataOut;
          else       rdata0_d = bus.mem_DataOut;
        end
        state_d = RESP;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rd_q         <= STROBE_OFF;
      wr_q         <= STROBE_OFF;
      daddr_q      <= '0;
      din_q        <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      daddr_q      <= daddr_d;
      din_q        <= din_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.mem_RD     = rd_q;
  assign bus.mem_WR     = wr_q;
  assign bus.mem_DAddr  = daddr_q;
  assign bus.mem_DataIn = din_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.err0       = err0_q;
  assign bus.err1       = err1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed, big-endian 32-bit data memory of the multi-cycle CPU.
- Requester 0 is the CPU MEM stage. Requester 1 is the debug/loader port.
- Grants one word access at a time, round-robin. Drives the memory's active-low RD/WR strobes for exactly one cycle and returns read data with a one-cycle ack pulse.
- Rejects misaligned or out-of-range accesses with an error pulse; the memory is not touched.

Parameters:
- ADDR_W, 32, requester and memory address width (byte address)
- DATA_W, 32, data word width
- MEM_BYTES, 128, memory size in bytes; legal word addresses are 0..MEM_BYTES-4

Ports:
- CLK  in  1  clock; all state changes on posedge
- Reset  in  1  synchronous, active-high reset
- req0, req1  in  1 each  access request; level, held until ack/err of that port
- we0, we1  in  1 each  1 = write, 0 = read; stable while req high
- addr0, addr1  in  ADDR_W each  byte address; stable while req high
- wdata0, wdata1  in  DATA_W each  write data; stable while req high
- ack0, ack1  out  1 each  one-cycle completion pulse
- err0, err1  out  1 each  one-cycle rejection pulse, mutually exclusive with ack
- rdata0, rdata1  out  DATA_W each  read data, valid in the ack cycle, held until next ack on that port
- mem_RD  out  1  memory read strobe, active-low
- mem_WR  out  1  memory write strobe, active-low
- mem_DAddr  out  ADDR_W  memory byte address
- mem_DataIn  out  DATA_W  memory write data
- mem_DataOut  in  DATA_W  memory read data (combinational from mem_DAddr)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, mem_RD=1, mem_WR=1, mem_DAddr=0, mem_DataIn=0, ack*=0, err*=0, rdata*=0, last_grant=1 (so port 0 wins first).
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the port that is not last_grant; last_grant updates on every grant.
  - On grant, latch the port's we/addr/wdata into mem_DAddr and mem_DataIn.
  - If addr[1:0]!=0 or addr>MEM_BYTES-4: go to ERR. Strobes stay high.
  - Otherwise go to ACCESS, and drive mem_WR=0 (write) or mem_RD=0 (read) for that one cycle.
- ACCESS:
  - Lasts exactly one cycle. The memory commits a write on the negedge inside this cycle.
  - At the closing posedge: capture mem_DataOut into rdata of the granted port (reads only), restore both strobes to 1, go to RESP.
- RESP: ack of the granted port =1 for this cycle only. Next state IDLE.
- ERR: err of the granted port =1 for this cycle only. rdata unchanged. Next state IDLE.
- Latency: req sampled at posedge T in IDLE → ACCESS in cycle T+1 → ack in cycle T+2. Three cycles per access; back-to-back throughput is one access per 3 cycles. An error response arrives in cycle T+1.
- Requester protocol:
  - A req still high in the cycle after its ack/err is a new request.
  - Requesters drop req in the ack/err cycle.
  - Changing we/addr/wdata while req is high and unacked is illegal; the latched values are used.
- Fairness: with both req continuously high, grants alternate 0,1,0,1. Neither port waits more than one other access.
- Strobes are never both low. A strobe is never low outside ACCESS.
- Reset during ACCESS:
  - A write whose negedge already occurred stays committed. No ack is issued.
  - Strobes return high at the reset edge.
  - Requesters re-issue after reset.
- Reset during RESP/ERR: the pulse is suppressed from the next cycle.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10, ERR=2'b11
  - strobe constants: STROBE_ON=1'b0, STROBE_OFF=1'b1
- Single natural sub-module: rr_arb2. Pure combinational 2-way round-robin pick from (req0, req1, last_grant) → (gnt_valid, gnt_id). The FSM and datapath latching stay in dmem_arbiter.

Test Plan:
- Port 0 write 0xDEADBEEF to addr 0x10 → mem_WR=0 for exactly one cycle with mem_DAddr=0x10, ack0 two cycles after req. A subsequent port 1 read of 0x10 → rdata1=0xDEADBEEF, and the memory bytes 0x10..0x13 are DE,AD,BE,EF.
- req0 and req1 both held high for 4 accesses from reset → grant order 0,1,0,1, acks spaced 3 cycles apart, no cycle with both strobes low.
- Port 1 read addr 0x06 (misaligned), then addr 0x7C (legal last word), then addr 0x80 (out of range) → err1, then ack1, then err1. No strobe activity for the two errors.
- Port 0 read of 0x20 while port 1 is idle → rdata0 equals the memory word; rdata1 unchanged; rdata0 holds its value after req0 drops.
- Reset asserted at the posedge ending ACCESS of a write of 0x12345678 to 0x04 → no ack0, strobes high next cycle, state IDLE. A later read of 0x04 returns 0x12345678.
- req0 kept high across its ack → a second access starts the cycle after ack, proving a re-request is treated as new and round-robin still admits a pending req1 first.
